interrupt_sequencer: RTL

//  Instruction-register stage for the cpu6502 core. Consumes the timing unit's sync
//  (T1, opcode fetch) and feeds the decoder. Latches the fetched opcode, or injects
//  BRK (8'h00) when reset, NMI or IRQ is pending. Selects the vector address the

---
 rtl/cpu6502_pkg.sv | 29 ++
 rtl/nmi_edge_detect.sv | 34 +++
 rtl/interrupt_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cpu6502_pkg.sv
// Shared constants and types for the cpu6502 instruction-register/interrupt stage.
package cpu6502_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 16;

  // Opcode injected into IR when an interrupt or reset sequence is taken
  localparam logic [DATA_W-1:0] OPCODE_BRK = 8'h00;

  // Default vector low-byte addresses
  localparam logic [ADDR_W-1:0] VEC_NMI_ADDR   = 16'hFFFA;
  localparam logic [ADDR_W-1:0] VEC_RESET_ADDR = 16'hFFFC;
  localparam logic [ADDR_W-1:0] VEC_IRQ_ADDR   = 16'hFFFE;

  typedef enum logic [1:0] {
    VSEL_RESET = 2'd0,
    VSEL_NMI   = 2'd1,
    VSEL_IRQ   = 2'd2
  } vector_sel_e;

  // Interrupt source priority: RESET > NMI > IRQ
  function automatic vector_sel_e vector_priority(input logic rst_pending,
                                                  input logic nmi_pending);
    if (rst_pending)      return VSEL_RESET;
    else if (nmi_pending) return VSEL_NMI;
    else                  return VSEL_IRQ;
  endfunction

endpackage

// File: rtl/nmi_edge_detect.sv
// NMI falling-edge detector with sticky pending flag.
// Samples every clock regardless of rdy so no edge is lost during a stall.
// Ports:
//   i_clk     clock (state updates on negedge)
//   i_reset   synchronous active-high reset
//   i_nmi_n   NMI pin, active-low, edge triggered
//   i_clear   clear request from the vector fetch of the NMI vector
//   o_pending NMI event waiting to be serviced
module nmi_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_nmi_n,
  input  logic i_clear,
  output logic o_pending
);

  logic nmi_prev;

  // A fresh edge wins over a clear in the same cycle so that event is not lost
  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      nmi_prev  <= 1'b1;
      o_pending <= 1'b0;
    end else begin
      nmi_prev <= i_nmi_n;
      if (nmi_prev && !i_nmi_n) begin
        o_pending <= 1'b1;
      end else if (i_clear) begin
        o_pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/interrupt_sequencer.sv
// Instruction-register stage of the cpu6502 core.
// Latches the opcode at T1 or injects BRK when reset/NMI/IRQ is pending,
// selects the vector the decoder fetches, and lets a pending NMI hijack an
// IRQ/BRK vector until the vector fetch locks it.
// Ports:
//   i_clk, i_reset       clock (negedge active), synchronous active-high reset
//   i_rdy                0 stalls IR/vector state (NMI/IRQ detectors keep sampling)
//   i_sync               opcode fetch cycle (T1)
//   i_data               data bus
//   i_nmi_n, i_irq_n     interrupt pins (NMI edge, IRQ level), active-low
//   i_flag_i             P.I interrupt-disable flag
//   i_vector_fetch       decoder fetches vector low byte this cycle
//   o_ir                 instruction register
//   o_forced             IR holds an injected BRK
//   o_wr_inhibit         reset sequence in progress: stack pushes become reads
//   o_vector_addr        vector low-byte address
module interrupt_sequencer
  import cpu6502_pkg::*;
#(
  parameter logic [ADDR_W-1:0] VEC_NMI   = VEC_NMI_ADDR,
  parameter logic [ADDR_W-1:0] VEC_RESET = VEC_RESET_ADDR,
  parameter logic [ADDR_W-1:0] VEC_IRQ   = VEC_IRQ_ADDR,
  parameter bit                HIJACK_EN = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rdy,
  input  logic              i_sync,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_nmi_n,
  input  logic              i_irq_n,
  input  logic              i_flag_i,
  input  logic              i_vector_fetch,
  output logic [DATA_W-1:0] o_ir,
  output logic              o_forced,
  output logic              o_wr_inhibit,
  output logic [ADDR_W-1:0] o_vector_addr
);

  logic [DATA_W-1:0] ir_q,  ir_d;
  logic              forced_q, forced_d;
  logic              wr_inhibit_q, wr_inhibit_d;
  logic [ADDR_W-1:0] vector_q, vector_d;
  logic              rst_pending_q, rst_pending_d;
  logic              locked_q, locked_d;
  logic              irq_sampled_q, irq_sampled_d;
  logic              nmi_pending;
  logic              nmi_clear_c;
  vector_sel_e       vector_sel_c;
  logic [ADDR_W-1:0] vector_sel_addr_c;

  nmi_edge_detect u_nmi_edge_detect (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_nmi_n   (i_nmi_n),
    .i_clear   (nmi_clear_c),
    .o_pending (nmi_pending)
  );

  // Priority mux from pending sources to vector address
  always_comb begin
    vector_sel_c = vector_priority(rst_pending_q, nmi_pending);
    case (vector_sel_c)
      VSEL_RESET: vector_sel_addr_c = VEC_RESET;
      VSEL_NMI:   vector_sel_addr_c = VEC_NMI;
      default:    vector_sel_addr_c = VEC_IRQ;
    endcase
  end

  // Next-state: IR load, vector fetch/lock, NMI hijack
  always_comb begin
    ir_d          = ir_q;
    forced_d      = forced_q;
    wr_inhibit_d  = wr_inhibit_q;
    vector_d      = vector_q;
    rst_pending_d = rst_pending_q;
    locked_d      = locked_q;
    nmi_clear_c   = 1'b0;
    // IRQ eligibility is sampled every cycle, independent of rdy
    irq_sampled_d = ~i_irq_n & ~i_flag_i;

    if (i_rdy) begin
      if (i_sync) begin
        // Opcode fetch takes precedence; a coincident vector fetch is ignored
        locked_d = 1'b0;
        if (rst_pending_q || nmi_pending || irq_sampled_q) begin
          ir_d         = OPCODE_BRK;
          forced_d     = 1'b1;
          wr_inhibit_d = rst_pending_q;
          vector_d     = vector_sel_addr_c;
        end else begin
          ir_d         = i_data;
          forced_d     = 1'b0;
          wr_inhibit_d = 1'b0;
          vector_d     = VEC_IRQ;
        end
      end else if (i_vector_fetch) begin
        // Vector is frozen from the fetch until the next IR load
        locked_d = 1'b1;
        if (vector_q == VEC_RESET) rst_pending_d = 1'b0;
        if (vector_q == VEC_NMI)   nmi_clear_c   = 1'b1;
      end else if (HIJACK_EN && !locked_q && (vector_q == VEC_IRQ) && nmi_pending) begin
        vector_d = VEC_NMI;
      end
    end
  end

  always_ff @(negedge i_clk) begin
    if (i_reset) begin
      ir_q          <= OPCODE_BRK;
      forced_q      <= 1'b1;
      wr_inhibit_q  <= 1'b1;
      vector_q      <= VEC_RESET;
      rst_pending_q <= 1'b1;
      locked_q      <= 1'b0;
      irq_sampled_q <= 1'b0;
    end else begin
      ir_q          <= ir_d;
      forced_q      <= forced_d;
      wr_inhibit_q  <= wr_inhibit_d;
      vector_q      <= vector_d;
      rst_pending_q <= rst_pending_d;
      locked_q      <= locked_d;
      irq_sampled_q <= irq_sampled_d;
    end
  end

  assign o_ir          = ir_q;
  assign o_forced      = forced_q;
  assign o_wr_inhibit  = wr_inhibit_q;
  assign o_vector_addr = vector_q;

endmodule
